// File: rtl/alu_pkg.sv
// ALU op-code definitions shared by the ALU, the arbiter and any op decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined control codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [3:0]  control,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = d2[4:0];

    always_comb begin
        result = '0;
        case (control)
            ALU_ADD:  result = d1 + d2;
            ALU_SLL:  result = d1 << shamt;
            ALU_SLT:  result = {31'b0, $signed(d1) < $signed(d2)};
            ALU_SLTU: result = {31'b0, d1 < d2};
            ALU_XOR:  result = d1 ^ d2;
            ALU_SRL:  result = d1 >> shamt;
            ALU_OR:   result = d1 | d2;
            ALU_AND:  result = d1 & d2;
            ALU_SUB:  result = d1 - d2;
            ALU_SRA:  result = $signed(d1) >>> shamt;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, with a one-deep
// tagged response register on a valid/ready channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_d1,
    input  logic [NUM_REQ*32-1:0] req_d2,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_illegal
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_illegal_q, rsp_illegal_d;

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               found;
    logic               free;
    logic               fire;

    logic [31:0]        mux_d1, mux_d2, alu_result;
    logic [3:0]         mux_op;

    // Requesters at or above ptr win first; fall back to the lowest index
    // when none of them is valid, which gives the wrap-around search.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i >= 32'(ptr_q));
        end
        masked  = req_valid & hi_mask;
        cand    = (|masked) ? masked : req_valid;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gnt_idx  = ID_W'(i);
            end
        end
    end

    assign free      = !rsp_valid_q || rsp_ready;
    assign req_ready = grant & {NUM_REQ{free}};
    assign fire      = |(req_valid & req_ready);

    always_comb begin
        mux_d1 = '0;
        mux_d2 = '0;
        mux_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mux_d1 = mux_d1 | req_d1[32*i +: 32];
                mux_d2 = mux_d2 | req_d2[32*i +: 32];
                mux_op = mux_op | req_op[4*i +: 4];
            end
        end
    end

    alu u_alu (
        .d1      (mux_d1),
        .d2      (mux_d2),
        .control (mux_op),
        .result  (alu_result)
    );

    always_comb begin
        ptr_d         = ptr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_illegal_d = rsp_illegal_q;
        if (fire) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = gnt_idx;
            rsp_result_d  = alu_result;
            rsp_illegal_d = !alu_op_legal(mux_op);
            ptr_d         = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between NUM_REQ requesters (for example the EX stage and an auxiliary unit). It arbitrates round-robin among requesters holding valid operands, launches the winning operation through the ALU, and captures the result in a one-deep output register. The response is returned on a single valid/ready channel tagged with the requester ID. The block sits between the requesters' operand buses and the write-back or consumer logic.

## Interface
- NUM_REQ, default 2: number of requesters, 2..8.
- ID_W, default $clog2(NUM_REQ): width of the requester ID.
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous active-low reset.
- req_valid  in  NUM_REQ: per-requester request valid.
- req_ready  out  NUM_REQ: per-requester accept.
- req_d1  in  NUM_REQ*32: operand 1, packed; requester i at [32i+31:32i].
- req_d2  in  NUM_REQ*32: operand 2, packed the same way.
- req_op  in  NUM_REQ*4: ALU control code, packed; requester i at [4i+3:4i].
- rsp_valid  out  1: response register holds a result.
- rsp_ready  in  1: consumer accepts the response.
- rsp_id  out  ID_W: index of the requester that produced the result.
- rsp_result  out  32: ALU result.
- rsp_illegal  out  1: the op code was not a defined ALU code.

## Operation
- Op codes: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
- Any other code: result 0 and rsp_illegal=1. The request is still consumed normally.
- Shift amounts use d2[4:0]. Add and subtract wrap modulo 2^32.
- Priority pointer `ptr` (ID_W bits) marks the highest-priority requester.
  - The grant goes to the first i with req_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
  - Grant is one-hot or zero.
- Slot free: `free = !rsp_valid || rsp_ready`.
- req_ready[i] = grant[i] && free. req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready.
- Fire: any req_valid[i] && req_ready[i]. On fire:
  - The response register loads the ALU result, illegal flag and i.
  - rsp_valid is set to 1.
  - ptr becomes (i+1) mod NUM_REQ.
- No fire, and rsp_valid && rsp_ready: rsp_valid is cleared. rsp_result, rsp_id and rsp_illegal hold their last values.
- No fire and no drain: all state holds, including ptr.
- Requester rule: once req_valid is asserted, it and its operands stay stable until req_ready. Retraction is forbidden.
  - A higher-priority requester asserting later may still win the next grant.
  - Round-robin bounds the wait to NUM_REQ-1 other grants.
- Consumer rule: while rsp_valid && !rsp_ready, rsp_result, rsp_id and rsp_illegal stay stable.

## Timing
- Reset (async assert, sync release): rsp_valid=0, rsp_result=0, rsp_id=0, rsp_illegal=0, ptr=0. req_ready is then 0 wherever req_valid=0.
- Latency: a request accepted at edge k shows rsp_valid=1 in the cycle after edge k.
- Throughput: one operation per cycle while rsp_ready=1.
- Drain and fire in the same cycle: the register is overwritten with the new result and rsp_valid stays 1. There is no bubble.
- Back-pressure: with rsp_valid=1 and rsp_ready=0, all req_ready=0 and ptr is frozen.
- Reset mid-operation: a pending response is discarded and ptr returns to 0. Requesters re-present after reset.
- There is no combinational path from req_* to rsp_*.

## Structure
- Shared package `alu_pkg`:
  - The ALU op-code localparams (ALU_ADD ... ALU_SRA).
  - A function `alu_op_legal(op)` returning 1 for the ten defined codes.
  - Reusable by the decoder.
- Sub-module: the existing combinational `alu`, instantiated once. Its d1/d2/control are driven by the granted requester's fields through a one-hot mux. The op field is zero when there is no grant.
- Round-robin grant logic stays inline as a combinational function of req_valid and ptr.

## Test plan
- Single request, NUM_REQ=2: req0 ADD d1=5, d2=7, rsp_ready=1 → next cycle rsp_valid=1, rsp_result=12, rsp_id=0, rsp_illegal=0.
- Contention: both valid every cycle, req0 SUB 10-3, req1 SRA 0x80000000>>>4, rsp_ready=1 → responses alternate id 0 (7), id 1 (0xF8000000), id 0, ... starting with id 0 after reset.
- Back-pressure: rsp_ready=0 for 3 cycles after a response is held → rsp_* stable, req_ready=0, ptr unchanged. Then rsp_ready=1 → the pending result drains and a new result loads the same cycle.
- Illegal op: req1 op=4'b1111, d1=d2=0xFFFFFFFF → rsp_result=0, rsp_illegal=1, rsp_id=1, and the requester is released.
- Compare edge cases: SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0; SLL 1 by d2=33 → 2.
- Reset mid-stream: assert rst_n=0 while rsp_valid=1 and ptr=1 → rsp_valid=0 and rsp_result=0 immediately, and the first grant after release goes to req0.
